// File: rtl/de3_uart_pkg.sv
// Shared definitions for the DE3 UART blocks: FSM state encoding,
// character width, counter width and the baud divisor helper.
// A matching transmitter is expected to import this package as well.
package de3_uart_pkg;

  // Data bits per character (7-bit ASCII)
  localparam int CHAR_W = 7;

  // Width of the baud counter; sized for any divisor below 65536
  localparam int CNT_W = 16;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  // Clock cycles per bit time, truncated. Callers need a result >= 4 so the
  // half-bit start sample lands at least two cycles into the start bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/de3_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line.
// Both stages reset to 1 so a freshly reset receiver sees an idle line.
module de3_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/de3_uart_rx.sv
// 7-bit UART receiver for the board display path.
// Frame: start(0), 7 data bits LSB first, optional even parity, stop(1).
// Good characters appear on char with a one-cycle char_valid strobe;
// a low stop bit gives a one-cycle frame_err strobe and the line must
// return high before another start bit is accepted.
// Build option: define DE3_UART_RX_PARITY_EN for 7E1 framing with a
// parity_err strobe; otherwise the frame is 7N1 and parity_err is tied 0.
module de3_uart_rx
  import de3_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [CHAR_W-1:0] char,
  output logic              char_valid,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);

  // Terminal counts: a full bit time, and half a bit to reach mid start bit
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(CHAR_W - 1);

  // Synchronized line and falling-edge detection
  logic rxd_s;
  logic rxd_prev_reg;
  logic [1:0] warm_reg;
  logic fall;

  // FSM
  rx_state_t state_reg;
  rx_state_t state_next;

  // Datapath
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic [CHAR_W-1:0] shift_reg;
  logic              tick;
  logic              parity_ok;

  // Control decoded from state
  logic cnt_clear;
  logic shift_en;
  logic char_load;
  logic frame_set;

`ifdef DE3_UART_RX_PARITY_EN
  logic parity_en;
  logic parity_set;
  logic parity_ok_reg;
`endif

  de3_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  // Previous-value register for the start edge. The synchronizer's reset value
  // of 1 is not a real observation of the line, so the previous value is held
  // at 0 until the pipeline has refilled from the pin. A line held low across
  // reset therefore never produces a 1->0 edge until it has genuinely gone high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_reg     <= 2'd0;
      rxd_prev_reg <= 1'b0;
    end else begin
      if (warm_reg != 2'd2) begin
        warm_reg <= warm_reg + 2'd1;
      end
      rxd_prev_reg <= (warm_reg == 2'd2) ? rxd_s : 1'b0;
    end
  end

  assign fall = rxd_prev_reg & ~rxd_s;

  // Sample point: half a bit into the start bit, a full bit in every later state
  always_comb begin
    if (state_reg == ST_START) begin
      tick = (cnt_reg == HALF_LAST);
    end else begin
      tick = (cnt_reg == FULL_LAST);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fall) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          // A line already back high at mid start bit was a glitch
          state_next = rxd_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && (bit_cnt_reg == LAST_BIT)) begin
`ifdef DE3_UART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_next = rxd_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxd_s) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output/control decode from state, sample tick and sampled line value
  always_comb begin
    cnt_clear = (state_reg == ST_IDLE) || (state_reg == ST_BREAK) || tick;
    shift_en  = (state_reg == ST_DATA) && tick;
    char_load = (state_reg == ST_STOP) && tick && rxd_s && parity_ok;
    frame_set = (state_reg == ST_STOP) && tick && !rxd_s;
`ifdef DE3_UART_RX_PARITY_EN
    parity_en  = (state_reg == ST_PARITY) && tick;
    parity_set = (state_reg == ST_STOP) && tick && rxd_s && !parity_ok;
`endif
  end

  // Baud counter: restarts at every sample point and while waiting for a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_clear) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Data shift register (LSB arrives first, so shift in from the top) and bit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bit_cnt_reg <= 3'd0;
    end else begin
      if (state_reg == ST_START) begin
        bit_cnt_reg <= 3'd0;
      end else if (shift_en) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
      if (shift_en) begin
        shift_reg <= {rxd_s, shift_reg[CHAR_W-1:1]};
      end
    end
  end

`ifdef DE3_UART_RX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_ok_reg <= 1'b0;
    end else if (parity_en) begin
      parity_ok_reg <= (rxd_s == ^shift_reg);
    end
  end

  assign parity_ok = parity_ok_reg;
`else
  assign parity_ok = 1'b1;
`endif

  // Registered outputs: char moves only together with its char_valid strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char       <= '0;
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      char_valid <= char_load;
      frame_err  <= frame_set;
      if (char_load) begin
        char <= shift_reg;
      end
    end
  end

`ifdef DE3_UART_RX_PARITY_EN
  // Parity error strobe, mutually exclusive with char_valid and frame_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_set;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_de3_uart_rx.sv
// Testbench for de3_uart_rx at CLK_FREQ=1_600_000, BAUD=100_000 (16 clocks/bit).
// Frames are built bit by bit on rxd; for each frame the expected outcome
// (good char / frame error / parity error) and its cycle are queued, and a
// negedge monitor matches every observed strobe against that queue.
module tb_de3_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = 16;
`ifdef DE3_UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Pin fall to char_valid: sync + half bit + start/data (+parity) bits + output reg
  localparam int LAT = 2 + CPB / 2 + (8 + PAR) * CPB + 1;

  localparam int K_CV = 1;
  localparam int K_FE = 2;
  localparam int K_PE = 3;

  typedef struct {
    int         kind;
    logic [6:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [6:0] char;
  logic       char_valid;
  logic       frame_err;
  logic       parity_err;

  int   compared;
  int   mismatched;
  int   cyc;
  exp_t exp_q[$];
  logic [6:0] model_char;

  de3_uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .char       (char),
    .char_valid (char_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Wait n rising edges, then step 1 time unit past the edge
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    wait_cycles(CPB);
  endtask

  // One frame; leaves rxd at the stop-bit level
  task automatic send_frame(input logic [6:0] data, input logic stop_bit, input logic par_flip);
    exp_t e;
    logic par;
    par = (^data) ^ par_flip;
    e.data = data;
    e.cyc  = cyc + LAT;
    if (!stop_bit)                    e.kind = K_FE;
    else if ((PAR != 0) && par_flip)  e.kind = K_PE;
    else                              e.kind = K_CV;
    exp_q.push_back(e);
    $display("frame data=0x%02h stop=%0d parflip=%0d -> kind %0d at cycle %0d",
             data, stop_bit, par_flip, e.kind, e.cyc);
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(data[i]);
    if (PAR != 0) drive_bit(par);
    drive_bit(stop_bit);
  endtask

  // Strobe monitor and char-hold check
  always @(negedge clk) begin
    int   nstrobe;
    int   kind;
    exp_t e;
    if (rst_n) begin
      nstrobe = int'(char_valid) + int'(frame_err) + int'(parity_err);
      if (nstrobe != 0) begin
        kind = char_valid ? K_CV : (frame_err ? K_FE : K_PE);
        check_eq("multi_strobe", nstrobe, 1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_strobe", kind, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("strobe_kind", kind, e.kind);
          check_eq("strobe_cycle", cyc, e.cyc);
          if (e.kind == K_CV) begin
            check_eq("char", char, e.data);
            model_char = e.data;
          end else begin
            check_eq("char_kept", char, model_char);
          end
        end
      end else begin
        check_eq("char_hold", char, model_char);
        if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
          e = exp_q.pop_front();
          check_eq("missed_strobe", 0, e.kind);
        end
      end
    end
  end

  initial begin
    int gap;
    logic [6:0] d;
    logic stop_bit;
    logic par_flip;
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    model_char = 7'h00;
    rst_n      = 1'b0;
    rxd        = 1'b1;

    // Reset state
    wait_cycles(4);
    check_eq("rst_char", char, 7'h00);
    check_eq("rst_valid", char_valid, 1'b0);
    check_eq("rst_ferr", frame_err, 1'b0);
    check_eq("rst_perr", parity_err, 1'b0);
    rst_n = 1'b1;
    wait_cycles(2 * CPB);

    // Single character; latency checked by the monitor
    send_frame(7'h41, 1'b1, 1'b0);
    wait_cycles(3 * CPB);

    // Back-to-back, zero idle
    send_frame(7'h30, 1'b1, 1'b0);
    send_frame(7'h7F, 1'b1, 1'b0);
    wait_cycles(3 * CPB);

    // Bad stop bit, then line held low for 100 bit times
    send_frame(7'h55, 1'b0, 1'b0);
    rxd = 1'b0;
    wait_cycles(100 * CPB);
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    send_frame(7'h2C, 1'b1, 1'b0);
    wait_cycles(2 * CPB);

    // Short low glitch, then a good frame
    rxd = 1'b0;
    wait_cycles(5);
    rxd = 1'b1;
    wait_cycles(3 * CPB);
    send_frame(7'h12, 1'b1, 1'b0);
    wait_cycles(2 * CPB);

    // Reset during bit 3 of 0x6A
    d = 7'h6A;
    $display("frame data=0x%02h aborted by reset in bit 3", d);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rxd = d[3];
    wait_cycles(CPB / 2);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_char", char, 7'h00);
    check_eq("midrst_valid", char_valid, 1'b0);
    check_eq("midrst_ferr", frame_err, 1'b0);
    check_eq("midrst_q", exp_q.size(), 0);
    model_char = 7'h00;
    rxd = 1'b1;
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(2 * CPB);
    send_frame(7'h6A, 1'b1, 1'b0);
    wait_cycles(2 * CPB);

    // Reset released with the line low: nothing may start until it goes high
    $display("reset released with rxd held low");
    rst_n = 1'b0;
    rxd   = 1'b0;
    wait_cycles(3);
    check_eq("lowrst_char", char, 7'h00);
    model_char = 7'h00;
    rst_n = 1'b1;
    wait_cycles(40 * CPB);
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    send_frame(7'h5A, 1'b1, 1'b0);
    wait_cycles(2 * CPB);

`ifdef DE3_UART_RX_PARITY_EN
    // Parity good then parity bad
    send_frame(7'h41, 1'b1, 1'b0);
    wait_cycles(CPB);
    send_frame(7'h41, 1'b1, 1'b1);
    wait_cycles(2 * CPB);
`endif

    // Randomized frames with random gaps and occasional errors
    for (int n = 0; n < 24; n++) begin
      d        = 7'($urandom_range(0, 127));
      stop_bit = ($urandom_range(0, 7) != 0);
      par_flip = (PAR != 0) && ($urandom_range(0, 4) == 0);
      send_frame(d, stop_bit, par_flip);
      if (!stop_bit) begin
        rxd = 1'b1;
        wait_cycles(CPB + $urandom_range(0, 2 * CPB));
      end else begin
        gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
        if (gap != 0) wait_cycles(gap);
      end
    end

    // Drain outstanding expectations, bounded
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0) break;
      wait_cycles(1);
    end
    check_eq("drain", exp_q.size(), 0);
    wait_cycles(CPB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
